// File: rtl/loop_idx_gen_l1_pkg.sv
// Shared layer-1 definitions: loop bounds, sequencer states and the index
// width helper used by the sequencer, its counters and its interface.
package layer1_pkg;

    localparam int L1_KMAX      = 2;
    localparam int L1_JMAX      = 2;
    localparam int L1_LMAX      = 0;
    localparam int L1_NWIN      = 4;
    localparam int ADDER_STAGES = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Bits needed to hold 0..max_val, never less than one bit so that
    // degenerate loops (max_val == 0) still get a real signal.
    function automatic int idx_w(input int max_val);
        int w;
        w = $clog2(max_val + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/loop_idx_gen_l1_if.sv
// Control and index bus of the layer-1 loop sequencer. The slave side is the
// sequencer itself; the master side issues start/en and consumes the indices.
interface loop_idx_gen_l1_if
    import layer1_pkg::*;
#(
    parameter int KMAX = L1_KMAX,
    parameter int JMAX = L1_JMAX,
    parameter int LMAX = L1_LMAX,
    parameter int NWIN = L1_NWIN
);

    localparam int KW = idx_w(KMAX);
    localparam int JW = idx_w(JMAX);
    localparam int LW = idx_w(LMAX);
    localparam int WW = idx_w(NWIN - 1);

    logic          start;
    logic          en;
    logic [KW-1:0] k_idx;
    logic [JW-1:0] j_idx;
    logic [LW-1:0] l_idx;
    logic [WW-1:0] win_idx;
    logic          idx_valid;
    logic          k_zero;
    logic          temp_zero;
    logic          win_last;
    logic          done;
    logic          busy;

    modport master (
        output start, en,
        input  k_idx, j_idx, l_idx, win_idx,
        input  idx_valid, k_zero, temp_zero, win_last, done, busy
    );

    modport slave (
        input  start, en,
        output k_idx, j_idx, l_idx, win_idx,
        output idx_valid, k_zero, temp_zero, win_last, done, busy
    );

endinterface

// File: rtl/loop_idx_gen_l1_wrap_cnt.sv
// Wrapping index counter 0..MAX. Advances on inc, returns to 0 after MAX and
// flags that carry on wrap so counters can be chained into a nested loop.
module wrap_cnt
    import layer1_pkg::*;
#(
    parameter  int MAX = 1,
    localparam int W   = idx_w(MAX)
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] q,
    output logic         wrap
);

    localparam logic [W-1:0] MAX_Q = W'(MAX);

    logic at_max;

    // Equality against the bound keeps non-power-of-two ranges exact.
    assign at_max = (q == MAX_Q);
    assign wrap   = inc && at_max;

    // Index register: reset/clear to zero, otherwise step and wrap on inc.
    always_ff @(posedge clk) begin
        if (!rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (inc) begin
            q <= at_max ? '0 : q + W'(1);
        end
    end

endmodule

// File: rtl/loop_idx_gen_l1.sv
// Layer-1 nested loop sequencer. Walks K (inner), J, L (outer) over each
// output window for NWIN windows per frame, and emits the temp_zero/k_zero
// strobes consumed by the downstream R counter.
module loop_idx_gen_l1
    import layer1_pkg::*;
#(
    parameter int KMAX = L1_KMAX,
    parameter int JMAX = L1_JMAX,
    parameter int LMAX = L1_LMAX,
    parameter int NWIN = L1_NWIN
) (
    input logic              clk,
    input logic              rst,
    loop_idx_gen_l1_if.slave bus
);

    localparam int KW = idx_w(KMAX);
    localparam int JW = idx_w(JMAX);
    localparam int LW = idx_w(LMAX);
    localparam int WW = idx_w(NWIN - 1);

    state_t        state_q;
    state_t        state_d;
    logic          first_q;
    logic          first_d;
    logic          run;
    logic          idx_valid;
    logic          clr;
    logic          k_wrap;
    logic          j_wrap;
    logic          l_wrap;
    logic          win_wrap;
    logic [KW-1:0] k_q;
    logic [JW-1:0] j_q;
    logic [LW-1:0] l_q;
    logic [WW-1:0] win_q;

    assign run       = (state_q == RUN);
    assign idx_valid = run && bus.en;
    // Counters are held at zero whenever no frame is running, so a new frame
    // always starts at (0,0,0,0) and the final wrap leaves them at zero too.
    assign clr       = !run;

    // Each counter carries into the next: K -> J -> L -> WIN. The WIN carry
    // is the final iteration of the frame.
    wrap_cnt #(.MAX(KMAX)) u_k (
        .clk  (clk),
        .rst  (rst),
        .inc  (idx_valid),
        .clr  (clr),
        .q    (k_q),
        .wrap (k_wrap)
    );

    wrap_cnt #(.MAX(JMAX)) u_j (
        .clk  (clk),
        .rst  (rst),
        .inc  (k_wrap),
        .clr  (clr),
        .q    (j_q),
        .wrap (j_wrap)
    );

    wrap_cnt #(.MAX(LMAX)) u_l (
        .clk  (clk),
        .rst  (rst),
        .inc  (j_wrap),
        .clr  (clr),
        .q    (l_q),
        .wrap (l_wrap)
    );

    wrap_cnt #(.MAX(NWIN - 1)) u_win (
        .clk  (clk),
        .rst  (rst),
        .inc  (l_wrap),
        .clr  (clr),
        .q    (win_q),
        .wrap (win_wrap)
    );

    // State and first-iteration flag registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            first_q <= 1'b0;
        end else begin
            state_q <= state_d;
            first_q <= first_d;
        end
    end

    // Next state: start only honoured in IDLE; DONE always lasts one cycle.
    always_comb begin
        state_d = state_q;
        first_d = first_q;
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    first_d = 1'b1;
                end
            end
            RUN: begin
                if (idx_valid) begin
                    first_d = 1'b0;
                end
                if (win_wrap) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Strobes are pure functions of state, indices and en, so they are
    // silent in IDLE/DONE and during stalls. k_zero and win_last coincide
    // with the K and L carries respectively.
    assign bus.k_idx     = k_q;
    assign bus.j_idx     = j_q;
    assign bus.l_idx     = l_q;
    assign bus.win_idx   = win_q;
    assign bus.idx_valid = idx_valid;
    assign bus.k_zero    = k_wrap;
    assign bus.temp_zero = idx_valid && first_q;
    assign bus.win_last  = l_wrap;
    assign bus.done      = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_loop_idx_gen_l1.sv
// Directed bench for the layer-1 loop sequencer: a KMAX=2,JMAX=2,LMAX=0,
// NWIN=2 instance for the frame scenarios and an all-zero-bound instance.
module tb_loop_idx_gen_l1;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    loop_idx_gen_l1_if #(.KMAX(2), .JMAX(2), .LMAX(0), .NWIN(2)) ia ();
    loop_idx_gen_l1_if #(.KMAX(0), .JMAX(0), .LMAX(0), .NWIN(1)) ib ();

    loop_idx_gen_l1 #(.KMAX(2), .JMAX(2), .LMAX(0), .NWIN(2)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ia.slave)
    );

    loop_idx_gen_l1 #(.KMAX(0), .JMAX(0), .LMAX(0), .NWIN(1)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ib.slave)
    );

    // {k[1:0], j[1:0], l, win, idx_valid, k_zero, temp_zero, win_last, done, busy}
    logic [11:0] obs_a;
    // {k, j, l, win, idx_valid, k_zero, temp_zero, win_last, done, busy}
    logic [9:0]  obs_b;

    assign obs_a = {ia.k_idx, ia.j_idx, ia.l_idx, ia.win_idx, ia.idx_valid,
                    ia.k_zero, ia.temp_zero, ia.win_last, ia.done, ia.busy};
    assign obs_b = {ib.k_idx, ib.j_idx, ib.l_idx, ib.win_idx, ib.idx_valid,
                    ib.k_zero, ib.temp_zero, ib.win_last, ib.done, ib.busy};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b0;
        ia.start = 1'b0; ia.en = 1'b0;
        ib.start = 1'b0; ib.en = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (obs_a !== 12'd0) begin
            n_fail++; $display("FAIL reset_a got=%h want=%h", obs_a, 12'd0);
        end
        n_checks++;
        if (obs_b !== 10'd0) begin
            n_fail++; $display("FAIL reset_b got=%h want=%h", obs_b, 10'd0);
        end
        @(negedge clk); rst = 1'b1;
    endtask

    task automatic test_nominal();
        logic [11:0] exp;
        int kz_cnt = 0;
        int tz_cnt = 0;
        int done_cnt = 0;
        @(negedge clk); ia.start = 1'b1; ia.en = 1'b1; #1;
        n_checks++;
        if (obs_a !== 12'd0) begin
            n_fail++; $display("FAIL nominal_idle got=%h want=%h", obs_a, 12'd0);
        end
        for (int t = 1; t <= 20; t++) begin
            @(negedge clk); ia.start = 1'b0; #1;
            if (t <= 18)
                exp = {2'((t-1)%3), 2'(((t-1)/3)%3), 1'b0, 1'((t-1)/9), 1'b1,
                       ((t-1)%3 == 2), (t == 1), (t == 9 || t == 18), 1'b0, 1'b1};
            else if (t == 19)
                exp = 12'b0000_0000_0011;
            else
                exp = 12'd0;
            n_checks++;
            if (obs_a !== exp) begin
                n_fail++; $display("FAIL nominal_c%0d got=%h want=%h", t, obs_a, exp);
            end
            kz_cnt += int'(ia.k_zero);
            tz_cnt += int'(ia.temp_zero);
            done_cnt += int'(ia.done);
        end
        n_checks++;
        if (kz_cnt != 6) begin
            n_fail++; $display("FAIL nominal_kzero_count got=%0d want=6", kz_cnt);
        end
        n_checks++;
        if (tz_cnt != 1) begin
            n_fail++; $display("FAIL nominal_tzero_count got=%0d want=1", tz_cnt);
        end
        n_checks++;
        if (done_cnt != 1) begin
            n_fail++; $display("FAIL nominal_done_count got=%0d want=1", done_cnt);
        end
    endtask

    task automatic test_reset_mid_frame();
        logic [11:0] exp;
        @(negedge clk); ia.start = 1'b1; ia.en = 1'b1;
        for (int it = 0; it <= 5; it++) begin
            @(negedge clk); ia.start = 1'b0;
            if (it == 5) rst = 1'b0;
            #1;
            exp = {2'(it%3), 2'((it/3)%3), 1'b0, 1'b0, 1'b1,
                   (it%3 == 2), (it == 0), 1'b0, 1'b0, 1'b1};
            n_checks++;
            if (obs_a !== exp) begin
                n_fail++; $display("FAIL rstmid_it%0d got=%h want=%h", it, obs_a, exp);
            end
        end
        @(negedge clk); #1;
        n_checks++;
        if (obs_a !== 12'd0) begin
            n_fail++; $display("FAIL rstmid_after got=%h want=%h", obs_a, 12'd0);
        end
        @(negedge clk); rst = 1'b1; #1;
        n_checks++;
        if (obs_a !== 12'd0) begin
            n_fail++; $display("FAIL rstmid_release got=%h want=%h", obs_a, 12'd0);
        end
        @(negedge clk); #1;
        n_checks++;
        if (obs_a !== 12'd0) begin
            n_fail++; $display("FAIL rstmid_idle got=%h want=%h", obs_a, 12'd0);
        end
    endtask

    task automatic test_stall();
        logic [11:0] exp;
        logic stall;
        int it = 0;
        int ns = 0;
        int kz_cnt = 0;
        int run_cyc = 0;
        @(negedge clk); ia.start = 1'b1; ia.en = 1'b1;
        for (int t = 1; t <= 23; t++) begin
            stall = (it == 7) && (ns < 3);
            @(negedge clk); ia.start = 1'b0; ia.en = !stall; #1;
            if (it < 18)
                exp = {2'(it%3), 2'((it/3)%3), 1'b0, 1'(it/9), !stall,
                       !stall && (it%3 == 2), !stall && (it == 0),
                       !stall && (it%9 == 8), 1'b0, 1'b1};
            else if (it == 18)
                exp = 12'b0000_0000_0011;
            else
                exp = 12'd0;
            n_checks++;
            if (obs_a !== exp) begin
                n_fail++; $display("FAIL stall_c%0d got=%h want=%h", t, obs_a, exp);
            end
            kz_cnt += int'(ia.k_zero);
            if (ia.busy && !ia.done) run_cyc++;
            if (stall) ns++; else it++;
        end
        ia.en = 1'b1;
        n_checks++;
        if (kz_cnt != 6) begin
            n_fail++; $display("FAIL stall_kzero_count got=%0d want=6", kz_cnt);
        end
        n_checks++;
        if (run_cyc != 21) begin
            n_fail++; $display("FAIL stall_run_cycles got=%0d want=21", run_cyc);
        end
    endtask

    task automatic test_first_stall();
        logic [11:0] exp;
        logic stall;
        int it = 0;
        int ns = 0;
        int tz_cnt = 0;
        @(negedge clk); ia.start = 1'b1; ia.en = 1'b1;
        for (int t = 1; t <= 22; t++) begin
            stall = (it == 0) && (ns < 2);
            @(negedge clk); ia.start = 1'b0; ia.en = !stall; #1;
            if (it < 18)
                exp = {2'(it%3), 2'((it/3)%3), 1'b0, 1'(it/9), !stall,
                       !stall && (it%3 == 2), !stall && (it == 0),
                       !stall && (it%9 == 8), 1'b0, 1'b1};
            else if (it == 18)
                exp = 12'b0000_0000_0011;
            else
                exp = 12'd0;
            n_checks++;
            if (obs_a !== exp) begin
                n_fail++; $display("FAIL first_stall_c%0d got=%h want=%h", t, obs_a, exp);
            end
            tz_cnt += int'(ia.temp_zero);
            if (stall) ns++; else it++;
        end
        ia.en = 1'b1;
        n_checks++;
        if (tz_cnt != 1) begin
            n_fail++; $display("FAIL first_stall_tzero_count got=%0d want=1", tz_cnt);
        end
    endtask

    task automatic test_ignored_start();
        logic [11:0] exp;
        int done_cnt = 0;
        @(negedge clk); ia.start = 1'b1; ia.en = 1'b1;
        for (int it = 0; it <= 20; it++) begin
            @(negedge clk); ia.start = (it == 4 || it == 18); #1;
            if (it < 18)
                exp = {2'(it%3), 2'((it/3)%3), 1'b0, 1'(it/9), 1'b1,
                       (it%3 == 2), (it == 0), (it%9 == 8), 1'b0, 1'b1};
            else if (it == 18)
                exp = 12'b0000_0000_0011;
            else
                exp = 12'd0;
            n_checks++;
            if (obs_a !== exp) begin
                n_fail++; $display("FAIL ignored_start_it%0d got=%h want=%h", it, obs_a, exp);
            end
            done_cnt += int'(ia.done);
        end
        ia.start = 1'b0;
        n_checks++;
        if (done_cnt != 1) begin
            n_fail++; $display("FAIL ignored_start_done_count got=%0d want=1", done_cnt);
        end
    endtask

    task automatic test_degenerate();
        @(negedge clk); ib.start = 1'b1; ib.en = 1'b1; #1;
        n_checks++;
        if (obs_b !== 10'd0) begin
            n_fail++; $display("FAIL degen_idle got=%h want=%h", obs_b, 10'd0);
        end
        @(negedge clk); ib.start = 1'b0; #1;
        n_checks++;
        if (obs_b !== 10'b0000_111101) begin
            n_fail++; $display("FAIL degen_iter got=%h want=%h", obs_b, 10'b0000_111101);
        end
        @(negedge clk); #1;
        n_checks++;
        if (obs_b !== 10'b0000_000011) begin
            n_fail++; $display("FAIL degen_done got=%h want=%h", obs_b, 10'b0000_000011);
        end
        @(negedge clk); #1;
        n_checks++;
        if (obs_b !== 10'd0) begin
            n_fail++; $display("FAIL degen_after got=%h want=%h", obs_b, 10'd0);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_reset_mid_frame();
        test_stall();
        test_first_stall();
        test_ignored_start();
        test_degenerate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
